state_history_logger: RTL

- Parametrised debug-state history recorder; next generation of the 8-bit current/previous state logger.
- Samples a sequencer's debug-state bus (power/reset FSM). On every state change it pushes the departing state and its dwell time (in tick units) into a DEPTH-entry circular history.
- Supports a sticky freeze, so the history survives a fault event, and an indexed readout port for register/SMBus mailbox access.

---
 rtl/state_history_logger.sv | 124 ++++++++++++
 1 files changed

// File: rtl/state_history_logger.sv
// Debug-state history recorder: logs each departed state with its dwell time
// into a circular buffer, with sticky freeze and indexed registered readout.
module state_history_logger #(
   parameter int unsigned WIDTH    = 8,
   parameter int unsigned DEPTH    = 8,
   parameter int unsigned DW_WIDTH = 16,
   parameter int unsigned IDX_W    = $clog2(DEPTH)
) (
   input  logic                iClk,
   input  logic                iRst_n,
   input  logic                iClear,
   input  logic                iTick,
   input  logic                iFreeze,
   input  logic [WIDTH-1:0]    iDbgSt,
   input  logic [IDX_W-1:0]    iRdIdx,
   output logic [WIDTH-1:0]    oCurrentState,
   output logic [WIDTH-1:0]    oPrevState,
   output logic [DW_WIDTH-1:0] oDwell,
   output logic [WIDTH-1:0]    oRdState,
   output logic [DW_WIDTH-1:0] oRdDwell,
   output logic                oRdValid,
   output logic [IDX_W:0]      oCount,
   output logic                oOverflow,
   output logic                oFrozen
);

   localparam int unsigned CNT_W = IDX_W + 1;
   localparam logic [CNT_W-1:0] FULL = CNT_W'(DEPTH);

   logic [WIDTH-1:0]    cur_q,   cur_d;
   logic [DW_WIDTH-1:0] dwell_q, dwell_d;
   logic [IDX_W-1:0]    ptr_q,   ptr_d;
   logic [CNT_W-1:0]    cnt_q,   cnt_d;
   logic                ovf_q,   ovf_d;
   logic                frz_q,   frz_d;

   logic [WIDTH-1:0]    st_mem_q [DEPTH];
   logic [DW_WIDTH-1:0] dw_mem_q [DEPTH];

   logic [WIDTH-1:0]    rd_state_q;
   logic [DW_WIDTH-1:0] rd_dwell_q;
   logic                rd_valid_q;

   logic                change_c;
   logic                rd_valid_c;
   logic [DW_WIDTH-1:0] dwell_inc_c;
   logic [DW_WIDTH-1:0] dwell_final_c;
   logic [IDX_W-1:0]    rd_slot_c;
   logic [IDX_W-1:0]    prev_slot_c;

   // Next-state logic; everything except the freeze flag holds while frozen.
   always_comb begin
      cur_d   = cur_q;
      dwell_d = dwell_q;
      ptr_d   = ptr_q;
      cnt_d   = cnt_q;
      ovf_d   = ovf_q;
      frz_d   = frz_q | iFreeze;

      dwell_inc_c   = (dwell_q == '1) ? dwell_q : dwell_q + DW_WIDTH'(1);
      dwell_final_c = iTick ? dwell_inc_c : dwell_q;
      change_c      = !frz_q && (iDbgSt != cur_q);
      rd_slot_c     = ptr_q - IDX_W'(1) - iRdIdx;
      prev_slot_c   = ptr_q - IDX_W'(1);
      rd_valid_c    = CNT_W'(iRdIdx) < cnt_q;

      if (change_c) begin
         cur_d   = iDbgSt;
         dwell_d = '0;
         ptr_d   = ptr_q + IDX_W'(1);
         if (cnt_q == FULL) begin
            ovf_d = 1'b1;
         end else begin
            cnt_d = cnt_q + CNT_W'(1);
         end
      end else if (!frz_q && iTick) begin
         dwell_d = dwell_inc_c;
      end
   end

   always_ff @(posedge iClk) begin
      if (!iRst_n || iClear) begin
         cur_q      <= iDbgSt;
         dwell_q    <= '0;
         ptr_q      <= '0;
         cnt_q      <= '0;
         ovf_q      <= 1'b0;
         frz_q      <= 1'b0;
         rd_state_q <= '0;
         rd_dwell_q <= '0;
         rd_valid_q <= 1'b0;
         for (int unsigned i = 0; i < DEPTH; i++) begin
            st_mem_q[i] <= '0;
            dw_mem_q[i] <= '0;
         end
      end else begin
         cur_q   <= cur_d;
         dwell_q <= dwell_d;
         ptr_q   <= ptr_d;
         cnt_q   <= cnt_d;
         ovf_q   <= ovf_d;
         frz_q   <= frz_d;
         if (change_c) begin
            st_mem_q[ptr_q] <= cur_q;
            dw_mem_q[ptr_q] <= dwell_final_c;
         end
         // Readout sees the pre-write pointer and contents.
         rd_valid_q <= rd_valid_c;
         rd_state_q <= rd_valid_c ? st_mem_q[rd_slot_c] : '0;
         rd_dwell_q <= rd_valid_c ? dw_mem_q[rd_slot_c] : '0;
      end
   end

   assign oCurrentState = cur_q;
   assign oPrevState    = (cnt_q == '0) ? '0 : st_mem_q[prev_slot_c];
   assign oDwell        = dwell_q;
   assign oRdState      = rd_state_q;
   assign oRdDwell      = rd_dwell_q;
   assign oRdValid      = rd_valid_q;
   assign oCount        = cnt_q;
   assign oOverflow     = ovf_q;
   assign oFrozen       = frz_q;

endmodule
